// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its request scheduler: widths, opcodes
// and the scheduler state encoding.
package alu_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int CMD_W_DEF  = 4;
    localparam int RES_W_DEF  = 16;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_INC  = 4'd1,
        OP_SUB  = 4'd2,
        OP_DEC  = 4'd3,
        OP_MUL  = 4'd4,
        OP_DIV  = 4'd5,
        OP_SHR  = 4'd6,
        OP_SHL  = 4'd7,
        OP_AND  = 4'd8,
        OP_OR   = 4'd9,
        OP_INV  = 4'd10,
        OP_NAND = 4'd11,
        OP_NOR  = 4'd12,
        OP_XOR  = 4'd13,
        OP_XNOR = 4'd14,
        OP_BUF  = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } sched_state_e;

endpackage

// File: rtl/alu.sv
// 8-bit combinational ALU with a 16-bit result; output forced to zero when
// not enabled. Shift amounts use b[2:0]; divide by zero returns all ones.
module alu
    import alu_pkg::*;
(
    input  logic [DATA_W_DEF-1:0] i_a,
    input  logic [DATA_W_DEF-1:0] i_b,
    input  logic [CMD_W_DEF-1:0]  i_command,
    input  logic                  i_enable,
    output logic [RES_W_DEF-1:0]  o_y
);

    localparam int ZW = RES_W_DEF - DATA_W_DEF;

    logic [RES_W_DEF-1:0] w_a;
    logic [RES_W_DEF-1:0] w_b;
    logic [RES_W_DEF-1:0] w_y;
    logic [2:0]           w_sh;

    assign w_a  = {{ZW{1'b0}}, i_a};
    assign w_b  = {{ZW{1'b0}}, i_b};
    assign w_sh = i_b[2:0];

    always_comb begin
        w_y = '0;
        case (alu_op_e'(i_command))
            OP_ADD:  w_y = w_a + w_b;
            OP_INC:  w_y = w_a + RES_W_DEF'(1);
            OP_SUB:  w_y = w_a - w_b;
            OP_DEC:  w_y = w_a - RES_W_DEF'(1);
            OP_MUL:  w_y = w_a * w_b;
            OP_DIV:  w_y = (i_b == '0) ? '1 : (w_a / w_b);
            OP_SHR:  w_y = w_a >> w_sh;
            OP_SHL:  w_y = w_a << w_sh;
            OP_AND:  w_y = w_a & w_b;
            OP_OR:   w_y = w_a | w_b;
            OP_INV:  w_y = {{ZW{1'b0}}, ~i_a};
            OP_NAND: w_y = {{ZW{1'b0}}, ~(i_a & i_b)};
            OP_NOR:  w_y = {{ZW{1'b0}}, ~(i_a | i_b)};
            OP_XOR:  w_y = w_a ^ w_b;
            OP_XNOR: w_y = {{ZW{1'b0}}, ~(i_a ^ i_b)};
            OP_BUF:  w_y = w_a;
            default: w_y = '0;
        endcase
    end

    assign o_y = i_enable ? w_y : '0;

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester wins; on a tie the requester
// that was not granted last wins. Grant is one-hot or zero.
module rr_arb2 (
    input  logic [1:0] i_valid,
    input  logic       i_last_grant,
    output logic [1:0] o_grant
);

    always_comb begin
        o_grant = i_valid;
        if (&i_valid) begin
            o_grant = i_last_grant ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/alu_sched.sv
// Shares one ALU between two valid/ready requesters; one operation in flight,
// result returned on the owner's response channel.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | arbitrate; ready to the winner; latch operands on handshake
// EXEC    | ALU enabled; result captured at end of cycle
// RESP    | rsp_valid to owner; hold until owner's rsp_ready
module alu_sched
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CMD_W  = CMD_W_DEF,
    parameter int RES_W  = RES_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,

    input  logic              i_req0_valid,
    output logic              o_req0_ready,
    input  logic [DATA_W-1:0] i_req0_a,
    input  logic [DATA_W-1:0] i_req0_b,
    input  logic [CMD_W-1:0]  i_req0_cmd,

    input  logic              i_req1_valid,
    output logic              o_req1_ready,
    input  logic [DATA_W-1:0] i_req1_a,
    input  logic [DATA_W-1:0] i_req1_b,
    input  logic [CMD_W-1:0]  i_req1_cmd,

    output logic              o_rsp0_valid,
    input  logic              i_rsp0_ready,
    output logic [RES_W-1:0]  o_rsp0_y,

    output logic              o_rsp1_valid,
    input  logic              i_rsp1_ready,
    output logic [RES_W-1:0]  o_rsp1_y,

    output logic [DATA_W-1:0] o_alu_a,
    output logic [DATA_W-1:0] o_alu_b,
    output logic [CMD_W-1:0]  o_alu_cmd,
    output logic              o_alu_enable,
    input  logic [RES_W-1:0]  i_alu_y
);

    sched_state_e      r_state;
    sched_state_e      w_state_nxt;
    logic              r_last_grant;
    logic              r_owner;
    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    logic [CMD_W-1:0]  r_alu_cmd;
    logic [RES_W-1:0]  r_result;

    logic [1:0]        w_grant;
    logic              w_win;
    logic              w_accept;

    rr_arb2 u_arb (
        .i_valid      ({i_req1_valid, i_req0_valid}),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant)
    );

    assign w_win = w_grant[1];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_accept     = 1'b0;
        o_req0_ready = 1'b0;
        o_req1_ready = 1'b0;
        o_alu_enable = 1'b0;
        o_rsp0_valid = 1'b0;
        o_rsp1_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // grant is only ever set for a valid requester, so ready == handshake
                o_req0_ready = w_grant[0];
                o_req1_ready = w_grant[1];
                if (|w_grant) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                o_alu_enable = 1'b1;
                w_state_nxt  = ST_RESP;
            end
            ST_RESP: begin
                o_rsp0_valid = ~r_owner;
                o_rsp1_valid = r_owner;
                if (r_owner ? i_rsp1_ready : i_rsp0_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_cmd    <= '0;
            r_result     <= '0;
        end else begin
            if (w_accept) begin
                r_alu_a      <= w_win ? i_req1_a   : i_req0_a;
                r_alu_b      <= w_win ? i_req1_b   : i_req0_b;
                r_alu_cmd    <= w_win ? i_req1_cmd : i_req0_cmd;
                r_owner      <= w_win;
                r_last_grant <= w_win;
            end
            if (r_state == ST_EXEC) begin
                r_result <= i_alu_y;
            end
        end
    end

    assign o_alu_a   = r_alu_a;
    assign o_alu_b   = r_alu_b;
    assign o_alu_cmd = r_alu_cmd;
    assign o_rsp0_y  = r_result;
    assign o_rsp1_y  = r_result;

endmodule

// File: tb/tb_alu_sched.sv
// Bench for alu_sched with the real alu: directed scenarios plus random
// traffic, checked against a transaction-level reference model.
module tb_alu_sched;
    import alu_pkg::*;

    logic        clk;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [7:0]  req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_cmd, req1_cmd;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [15:0] rsp0_y, rsp1_y;
    logic [7:0]  alu_a, alu_b;
    logic [3:0]  alu_cmd;
    logic        alu_enable;
    logic [15:0] alu_y;

    int n_cmp = 0;
    int n_err = 0;

    alu_sched u_dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req0_valid (req0_valid),
        .o_req0_ready (req0_ready),
        .i_req0_a     (req0_a),
        .i_req0_b     (req0_b),
        .i_req0_cmd   (req0_cmd),
        .i_req1_valid (req1_valid),
        .o_req1_ready (req1_ready),
        .i_req1_a     (req1_a),
        .i_req1_b     (req1_b),
        .i_req1_cmd   (req1_cmd),
        .o_rsp0_valid (rsp0_valid),
        .i_rsp0_ready (rsp0_ready),
        .o_rsp0_y     (rsp0_y),
        .o_rsp1_valid (rsp1_valid),
        .i_rsp1_ready (rsp1_ready),
        .o_rsp1_y     (rsp1_y),
        .o_alu_a      (alu_a),
        .o_alu_b      (alu_b),
        .o_alu_cmd    (alu_cmd),
        .o_alu_enable (alu_enable),
        .i_alu_y      (alu_y)
    );

    alu u_alu (
        .i_a       (alu_a),
        .i_b       (alu_b),
        .i_command (alu_cmd),
        .i_enable  (alu_enable),
        .o_y       (alu_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] alu_ref(input int a, input int b, input int cmd);
        int r;
        case (cmd)
            0:  r = a + b;
            1:  r = a + 1;
            2:  r = a - b;
            3:  r = a - 1;
            4:  r = a * b;
            5:  r = (b == 0) ? 'hFFFF : a / b;
            6:  r = a >> (b % 8);
            7:  r = a << (b % 8);
            8:  r = a & b;
            9:  r = a | b;
            10: r = ~a & 'hFF;
            11: r = ~(a & b) & 'hFF;
            12: r = ~(a | b) & 'hFF;
            13: r = a ^ b;
            14: r = ~(a ^ b) & 'hFF;
            default: r = a;
        endcase
        return 16'(r & 'hFFFF);
    endfunction

    // transaction-level model: operation lifetime counted in cycles since grant
    bit          mon_en = 1'b0;
    bit          m_busy = 1'b0;
    int          m_age  = 0;
    bit          m_owner = 1'b0;
    bit          m_last  = 1'b1;
    logic [7:0]  m_a = '0, m_b = '0;
    logic [3:0]  m_cmd = '0;
    logic [15:0] m_exp = '0, m_res = '0;
    bit          e0, e1;
    int          n_en = 0, n_ops = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (!m_busy) begin
                e0 = req0_valid && (!req1_valid || m_last);
                e1 = req1_valid && (!req0_valid || !m_last);
            end else begin
                e0 = 1'b0;
                e1 = 1'b0;
            end
            check_val("m_rdy0",    32'(req0_ready), 32'(e0));
            check_val("m_rdy1",    32'(req1_ready), 32'(e1));
            check_val("m_en",      32'(alu_enable), 32'(m_busy && m_age == 1));
            check_val("m_rsp0_v",  32'(rsp0_valid), 32'(m_busy && m_age >= 2 && !m_owner));
            check_val("m_rsp1_v",  32'(rsp1_valid), 32'(m_busy && m_age >= 2 && m_owner));
            check_val("m_rsp0_y",  32'(rsp0_y), 32'(m_res));
            check_val("m_rsp1_y",  32'(rsp1_y), 32'(m_res));
            check_val("m_alu_a",   32'(alu_a), 32'(m_a));
            check_val("m_alu_b",   32'(alu_b), 32'(m_b));
            check_val("m_alu_cmd", 32'(alu_cmd), 32'(m_cmd));
            if (alu_enable === 1'b1) n_en++;
            if (rst) begin
                m_busy = 1'b0; m_age = 0; m_owner = 1'b0; m_last = 1'b1;
                m_a = '0; m_b = '0; m_cmd = '0; m_res = '0;
            end else if (!m_busy) begin
                if (e0 || e1) begin
                    m_owner = e1;
                    m_last  = e1;
                    m_a     = e1 ? req1_a   : req0_a;
                    m_b     = e1 ? req1_b   : req0_b;
                    m_cmd   = e1 ? req1_cmd : req0_cmd;
                    m_exp   = alu_ref(int'(m_a), int'(m_b), int'(m_cmd));
                    m_busy  = 1'b1;
                    m_age   = 1;
                    n_ops++;
                end
            end else begin
                if (m_age == 1) m_res = m_exp;
                else if (m_owner ? rsp1_ready : rsp0_ready) m_busy = 1'b0;
                m_age++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [7:0]  s_a, s_b;
    logic [3:0]  s_cmd;
    logic [15:0] s_exp, s_hold;
    bit          got;

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req0_cmd = '0;
        req1_a = '0; req1_b = '0; req1_cmd = '0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        tick();
        mon_en = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // single request on port 0
        req0_valid = 1'b1; req0_a = 8'd20; req0_b = 8'd10; req0_cmd = OP_ADD;
        @(negedge clk);
        check_val("t1_rdy0", 32'(req0_ready), 32'd1);
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        check_val("t1_exec_v", 32'(rsp0_valid), 32'd0);
        tick();
        @(negedge clk);
        check_val("t1_rsp_v", 32'(rsp0_valid), 32'd1);
        check_val("t1_y", 32'(rsp0_y), 32'd30);
        check_val("t1_rsp1_v", 32'(rsp1_valid), 32'd0);
        tick();

        // contention straight after reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req0_valid = 1'b1; req0_a = 8'd15; req0_b = 8'd15; req0_cmd = OP_MUL;
        req1_valid = 1'b1; req1_a = 8'd25; req1_b = 8'd17; req1_cmd = OP_SUB;
        @(negedge clk);
        check_val("t2_rdy0", 32'(req0_ready), 32'd1);
        check_val("t2_rdy1", 32'(req1_ready), 32'd0);
        tick();
        req0_valid = 1'b0;
        tick();
        @(negedge clk);
        check_val("t2_y0", 32'(rsp0_y), 32'h00E1);
        check_val("t2_v1", 32'(rsp1_valid), 32'd0);
        tick();
        @(negedge clk);
        check_val("t2_rdy1b", 32'(req1_ready), 32'd1);
        tick();
        req1_valid = 1'b0;
        tick();
        @(negedge clk);
        check_val("t2_v1b", 32'(rsp1_valid), 32'd1);
        check_val("t2_y1", 32'(rsp1_y), 32'd8);
        tick();

        // fairness with both ports continuously valid
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            got = 1'b0;
            for (int k = 0; k < 8 && !got; k++) begin
                @(negedge clk);
                if (req0_ready || req1_ready) got = 1'b1;
                else tick();
            end
            check_val("fair_wait", 32'(got), 32'd1);
            if (got) check_val("fair_grant", 32'({req1_ready, req0_ready}), (i % 2 == 1) ? 32'd2 : 32'd1);
            tick();
            req0_a = 8'($urandom); req0_b = 8'($urandom); req0_cmd = 4'($urandom);
            req1_a = 8'($urandom); req1_b = 8'($urandom); req1_cmd = 4'($urandom);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick(); tick(); tick();

        // back-pressure on port 1 while port 0 waits
        s_a = 8'd200; s_b = 8'd3; s_cmd = OP_SHL;
        s_exp = alu_ref(int'(s_a), int'(s_b), int'(s_cmd));
        rsp1_ready = 1'b0;
        req1_valid = 1'b1; req1_a = s_a; req1_b = s_b; req1_cmd = s_cmd;
        @(negedge clk);
        check_val("bp_grant1", 32'(req1_ready), 32'd1);
        tick();
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_a = 8'd9; req0_b = 8'd4; req0_cmd = OP_DIV;
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("bp_v1", 32'(rsp1_valid), 32'd1);
            check_val("bp_y1", 32'(rsp1_y), 32'(s_exp));
            check_val("bp_rdy0", 32'(req0_ready), 32'd0);
            tick();
        end
        rsp1_ready = 1'b1;
        @(negedge clk);
        check_val("bp_rdy0_last", 32'(req0_ready), 32'd0);
        tick();
        @(negedge clk);
        check_val("bp_grant0", 32'(req0_ready), 32'd1);
        tick();
        req0_valid = 1'b0;
        tick(); tick(); tick();

        // reset while in EXEC
        req0_valid = 1'b1; req0_a = 8'd77; req0_b = 8'd5; req0_cmd = OP_XOR;
        tick();
        req0_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check_val("rst_exec_en", 32'(alu_enable), 32'd1);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_val("rst_v0", 32'(rsp0_valid), 32'd0);
        check_val("rst_v1", 32'(rsp1_valid), 32'd0);
        check_val("rst_en", 32'(alu_enable), 32'd0);
        check_val("rst_a", 32'(alu_a), 32'd0);
        check_val("rst_b", 32'(alu_b), 32'd0);
        check_val("rst_cmd", 32'(alu_cmd), 32'd0);
        check_val("rst_y0", 32'(rsp0_y), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            check_val("rst_no_rsp", 32'(rsp0_valid), 32'd0);
        end
        tick();
        req0_valid = 1'b1; req0_a = 8'd7; req0_b = 8'd6; req0_cmd = OP_MUL;
        tick();
        req0_valid = 1'b0;
        tick();
        @(negedge clk);
        check_val("rst_after_v", 32'(rsp0_valid), 32'd1);
        check_val("rst_after_y", 32'(rsp0_y), 32'd42);
        tick();

        // random traffic with occasional resets and back-pressure
        for (int i = 0; i < 500; i++) begin
            req0_valid = ($urandom_range(0, 3) != 0);
            req1_valid = ($urandom_range(0, 3) != 0);
            req0_a = 8'($urandom); req0_b = 8'($urandom); req0_cmd = 4'($urandom);
            req1_a = 8'($urandom); req1_b = 8'($urandom); req1_cmd = 4'($urandom);
            rsp0_ready = ($urandom_range(0, 3) != 0);
            rsp1_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 63) == 0);
            tick();
        end
        rst = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();

        @(negedge clk);
        check_val("en_per_op", 32'(n_en), 32'(n_ops));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
